ram_port_scheduler: RTL
=======================

// Module: ram_port_scheduler
// PURPOSE
//  Owns the single-port word RAM shared by the serial receive path (writer) and the dump/transmit path (reader).
//  Grants one RAM access per cycle and tracks the count of stored words.
//  On a send request, streams every stored word, in address order, to the transmitter over a valid/ready handshake.
//  Sits between the serial receiver, the RAM and the serial transmitter.
// PARAMETERS
//  ADDR_W   8    RAM address width; capacity DEPTH = 2**ADDR_W words
//  DATA_W   16   RAM word width
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  wr_req       in   1       receiver has a word; held high until wr_ack
//  wr_data      in   DATA_W  word to store; stable while wr_req high
//  wr_ack       out  1       one-cycle pulse; word accepted (or dropped when full)
//  send         in   1       start-dump request; level or pulse, rising edge used
//  tx_valid     out  1       tx_data valid to transmitter
//  tx_ready     in   1       transmitter accepts tx_data this cycle
//  tx_data      out  DATA_W  word being dumped
//  ram_addr     out  ADDR_W  RAM address
//  ram_we       out  1       RAM write enable
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data; valid 1 cycle after address
//  word_count   out  ADDR_W+1  words stored (0..DEPTH)
//  busy         out  1       high in every state except IDLE
//  overflow     out  1       sticky; set when a write is dropped due to full
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; word_count 0; write pointer 0; overflow 0; send edge detector cleared.
//  States: IDLE, WRITE, RD_ADDR, RD_WAIT, TX_HOLD, DONE.
//  IDLE: wr_req -> WRITE (writes have priority); else send rising edge with word_count>0 -> RD_ADDR;
//    send edge with word_count==0 -> DONE directly.
//  WRITE (1 cycle): ram_we=1, ram_addr=wr_ptr, ram_wdata=wr_data, wr_ack=1, wr_ptr+1, word_count+1 -> IDLE.
//    Full (word_count==DEPTH): ram_we=0, wr_ack=1, overflow<=1, count/pointer unchanged.
//    A send edge arriving during WRITE is latched; dump starts from IDLE next cycle.
//  RD_ADDR: ram_addr=rd_ptr, ram_we=0 -> RD_WAIT.  RD_WAIT: register ram_rdata into tx_data, tx_valid=1 -> TX_HOLD.
//  TX_HOLD: hold tx_valid/tx_data until tx_ready; on handshake rd_ptr+1; if rd_ptr+1==word_count -> DONE
//    else -> RD_ADDR. Word rate is therefore at most one per 3 cycles.
//  DONE (1 cycle): rd_ptr<=0; tx_valid=0 -> IDLE.
//  During any read state wr_req is not acknowledged (wr_ack=0); receiver holds request, serviced after DONE.
//  Send edges during a dump are ignored (not queued).
//  Pointers are ADDR_W bits; wr_ptr wraps to 0 only when word_count reaches DEPTH (full, no further writes).
//  word_count is ADDR_W+1 bits so DEPTH is representable.
//  Reset mid-dump or mid-write: immediate return to reset state next edge; partially sent word abandoned.
//  ram_we asserted only in WRITE; never coincident with a read address phase.
// CONFIGURATION
//  RAM_SCHED_CLEAR_ON_DUMP_EN defined: in DONE also wr_ptr<=0, word_count<=0, overflow<=0 (buffer emptied after dump).
//  Not defined: stored words and count retained after dump; a later send re-dumps the same words plus any new ones.
// TESTING
//  Reset then 3 writes 0x0A01,0x0A02,0x0A03 -> ram_we at addr 0,1,2; wr_ack each; word_count=3.
//  send edge after 3 writes, tx_ready=1 -> tx_data 0x0A01,0x0A02,0x0A03 in order, then DONE, busy falls.
//  Same dump with tx_ready low 5 cycles on word 2 -> tx_data/tx_valid held stable, no skip or repeat.
//  wr_req and send edge same cycle in IDLE -> write committed first (count 4), dump then sends 4 words.
//  ADDR_W=2: 5 writes -> 4 stored, 5th acked with ram_we=0, overflow=1, word_count=4.
//  reset asserted mid TX_HOLD -> next cycle tx_valid=0, busy=0, word_count=0; send with macro on/off checks count after DONE (0 / retained).

Source files
------------

// File: rtl/ram_port_scheduler_if.sv
// Bundles the receiver, transmitter, RAM and status signals of ram_port_scheduler.
// The master modport is the scheduler side; the slave modport is the environment side.
interface ram_port_scheduler_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              send;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              overflow;

  modport master (
    input  wr_req, wr_data, send, tx_ready, ram_rdata,
    output wr_ack, tx_valid, tx_data, ram_addr, ram_we, ram_wdata,
           word_count, busy, overflow
  );

  modport slave (
    output wr_req, wr_data, send, tx_ready, ram_rdata,
    input  wr_ack, tx_valid, tx_data, ram_addr, ram_we, ram_wdata,
           word_count, busy, overflow
  );
endinterface

// File: rtl/ram_port_scheduler.sv
// Single-port RAM arbiter: serial writes fill the buffer, a send edge dumps it in address order.
// Optional macro RAM_SCHED_CLEAR_ON_DUMP_EN empties the buffer at the end of every dump.
module ram_port_scheduler #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_port_scheduler_if.master bus
);

  localparam logic [ADDR_W:0]   LP_DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LP_CNT_1  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LP_PTR_1  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_WAIT = 3'd3,
    S_TX_HOLD = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_send_d;
  logic              r_send_pend;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_word_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_tx_data;

  logic              w_send_rise;
  logic              w_send_evt;
  logic              w_full;
  logic              w_last;
  logic              w_wr_ack;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic              w_tx_valid;
  logic              w_busy;

  // A send edge seen while a write wins arbitration stays pending until IDLE can act on it.
  assign w_send_rise = bus.send & ~r_send_d;
  assign w_send_evt  = w_send_rise | r_send_pend;
  assign w_full      = (r_word_count == LP_DEPTH);
  assign w_last      = (({1'b0, r_rd_ptr} + LP_CNT_1) == r_word_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.wr_req) begin
          w_state_nxt = S_WRITE;
        end else if (w_send_evt) begin
          w_state_nxt = (r_word_count == '0) ? S_DONE : S_RD_ADDR;
        end
      end
      S_WRITE:   w_state_nxt = S_IDLE;
      S_RD_ADDR: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: w_state_nxt = S_TX_HOLD;
      S_TX_HOLD: begin
        if (bus.tx_ready) begin
          w_state_nxt = w_last ? S_DONE : S_RD_ADDR;
        end
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_ack    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    w_tx_valid  = 1'b0;
    w_busy      = (r_state != S_IDLE);
    unique case (r_state)
      S_WRITE: begin
        w_wr_ack    = 1'b1;
        w_ram_we    = ~w_full;
        w_ram_addr  = r_wr_ptr;
        w_ram_wdata = bus.wr_data;
      end
      S_RD_ADDR: w_ram_addr = r_rd_ptr;
      S_TX_HOLD: w_tx_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_send_d     <= 1'b0;
      r_send_pend  <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_send_d    <= bus.send;
      r_send_pend <= 1'b0;
      unique case (r_state)
        S_IDLE: r_send_pend <= bus.wr_req & w_send_evt;
        S_WRITE: begin
          r_send_pend <= r_send_pend | w_send_rise;
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_wr_ptr     <= r_wr_ptr + LP_PTR_1;
            r_word_count <= r_word_count + LP_CNT_1;
          end
        end
        S_RD_WAIT: r_tx_data <= bus.ram_rdata;
        S_TX_HOLD: begin
          if (bus.tx_ready) begin
            r_rd_ptr <= r_rd_ptr + LP_PTR_1;
          end
        end
        S_DONE: begin
          r_rd_ptr <= '0;
`ifdef RAM_SCHED_CLEAR_ON_DUMP_EN
          r_wr_ptr     <= '0;
          r_word_count <= '0;
          r_overflow   <= 1'b0;
`else
          r_wr_ptr     <= r_wr_ptr;
          r_word_count <= r_word_count;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_ack     = w_wr_ack;
  assign bus.ram_we     = w_ram_we;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_wdata  = w_ram_wdata;
  assign bus.tx_valid   = w_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.word_count = r_word_count;
  assign bus.busy       = w_busy;
  assign bus.overflow   = r_overflow;

endmodule
